crc_frame_monitor: RTL



---
 rtl/crc_mon_pkg.sv | 18 +
 rtl/crc_sat_counter.sv | 22 ++
 rtl/crc_frame_monitor.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/crc_mon_pkg.sv
// Shared types and constants for the frame CRC monitor.
package crc_mon_pkg;

  localparam int unsigned CRC_W                = 32;
  localparam int unsigned PIX_PER_WORD         = 4;
  localparam int unsigned DEFAULT_DRAIN_CYCLES = 4;
  // Drain counter width covers the legal DRAIN_CYCLES range 1..15.
  localparam int unsigned DRAIN_CNT_W          = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACTIVE,
    ST_DRAIN,
    ST_REPORT
  } crc_mon_state_e;

endpackage

// File: rtl/crc_sat_counter.sv
// Up-counter with synchronous clear and selectable saturate/wrap behaviour.
module crc_sat_counter #(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc; hold at all-ones when saturating, otherwise wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && !(SATURATE && (count == '1))) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/crc_frame_monitor.sv
// Frame-level gate, drain timer and CRC checker around the pixel-CRC pipeline.
module crc_frame_monitor
  import crc_mon_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int unsigned PIX_CNT_W    = 24,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vsync,
  input  logic                 pixel_valid_in,
  input  logic [CRC_W-1:0]     crc_in,
  input  logic                 golden_en,
  input  logic [CRC_W-1:0]     golden_crc,
  output logic                 pixel_valid_out,
  output logic                 crc_clear,
  output logic [CRC_W-1:0]     frame_crc,
  output logic                 frame_crc_valid,
  output logic [PIX_CNT_W-1:0] frame_pixels,
  output logic                 crc_match,
  output logic                 crc_repeat,
  output logic                 frame_partial,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     frame_count,
  output logic [CNT_W-1:0]     mismatch_count
);

  localparam int unsigned                PART_W     = $clog2(PIX_PER_WORD);
  localparam logic [DRAIN_CNT_W-1:0]     DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  crc_mon_state_e          state, state_nxt;
  logic                    vsync_d;
  logic                    vs_rise;
  logic                    in_guard;
  logic                    report_cyc;
  logic                    boundary_evt;
  logic                    match_now;
  logic [DRAIN_CNT_W-1:0]  drain_cnt;
  logic [PIX_CNT_W-1:0]    pix_cnt;
  logic                    err_flag;
  logic                    have_prev;
  logic [CRC_W-1:0]        prev_crc;

  assign vs_rise      = vsync & ~vsync_d;
  assign boundary_evt = in_guard & (pixel_valid_in | vs_rise);
  assign match_now    = ~golden_en | (crc_in == golden_crc);

  // Delay vsync by one cycle for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) vsync_d <= 1'b0;
    else     vsync_d <= vsync;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; vsync edges outside IDLE/ACTIVE do not move the FSM.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (vs_rise) state_nxt = ST_SYNC;
      ST_SYNC:   state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (vs_rise) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_cnt == '0) state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = ST_ACTIVE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State decodes: pixel gate, CRC clear and boundary-window flag.
  always_comb begin
    pixel_valid_out = 1'b0;
    crc_clear       = 1'b0;
    in_guard        = 1'b0;
    report_cyc      = 1'b0;
    unique case (state)
      ST_SYNC: begin
        crc_clear = 1'b1;
        in_guard  = 1'b1;
      end
      ST_ACTIVE: pixel_valid_out = pixel_valid_in;
      ST_DRAIN:  in_guard = 1'b1;
      ST_REPORT: begin
        crc_clear  = 1'b1;
        in_guard   = 1'b1;
        report_cyc = 1'b1;
      end
      default: ;
    endcase
  end

  // Drain timer: loaded on the frame-end edge, counts down through DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if ((state == ST_ACTIVE) && vs_rise) begin
      drain_cnt <= DRAIN_LOAD;
    end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
      drain_cnt <= drain_cnt - DRAIN_CNT_W'(1);
    end
  end

  // Boundary error flag; an event in REPORT itself belongs to the next frame.
  always_ff @(posedge clk) begin
    if (rst)             err_flag <= 1'b0;
    else if (report_cyc) err_flag <= boundary_evt;
    else if (boundary_evt) err_flag <= 1'b1;
  end

  // Capture frame results in REPORT; they become visible in the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_crc       <= '0;
      frame_crc_valid <= 1'b0;
      frame_pixels    <= '0;
      crc_match       <= 1'b0;
      crc_repeat      <= 1'b0;
      frame_partial   <= 1'b0;
      frame_err       <= 1'b0;
      prev_crc        <= '0;
      have_prev       <= 1'b0;
    end else begin
      frame_crc_valid <= report_cyc;
      if (report_cyc) begin
        frame_crc     <= crc_in;
        frame_pixels  <= pix_cnt;
        frame_partial <= (pix_cnt[PART_W-1:0] != '0);
        crc_match     <= match_now;
        crc_repeat    <= have_prev & (crc_in == prev_crc);
        frame_err     <= err_flag;
        prev_crc      <= crc_in;
        have_prev     <= 1'b1;
      end
    end
  end

  crc_sat_counter #(
    .WIDTH    (PIX_CNT_W),
    .SATURATE (1'b1)
  ) u_pix_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (report_cyc),
    .inc   (pixel_valid_out),
    .count (pix_cnt)
  );

  crc_sat_counter #(
    .WIDTH    (CNT_W),
    .SATURATE (1'b0)
  ) u_frame_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (report_cyc),
    .count (frame_count)
  );

  crc_sat_counter #(
    .WIDTH    (CNT_W),
    .SATURATE (1'b1)
  ) u_mismatch_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (report_cyc & ~match_now),
    .count (mismatch_count)
  );

endmodule
